// File: rtl/rsa_modexp_ctrl.sv
// Purpose : sequencer for a shared Montgomery multiplier; computes X^E mod M by left-to-right
//           square-and-multiply in the Montgomery domain (X~ = MM(X,R2), A = R, per bit A=MM(A,A)
//           then A=MM(A,X~) on a 1, result = MM(A,1)).
// Latency : (2 + EXP_WIDTH + popcount(E)) multiplies, each ISSUE cycle + multiplier latency, plus 2 cycles.
// Backpressure: none; start is only sampled in IDLE, start while busy is dropped.
//
// Ports:
//   clk, resetn (synchronous, active-low)
//   start, in_x, in_e, in_m, in_r (R mod M), in_r2 (R^2 mod M) : request, registered on accept
//   mm_start/mm_a/mm_b/mm_m -> multiplier;  mm_result/mm_done <- multiplier
//   result, done (pulse), busy, err (even modulus)
//
// Optional feature macro: MODEXP_LZ_SKIP_EN -- skips leading zero exponent bits with a one-bit-per-cycle
// SCAN state before the first squaring, so leading zeros cost no multiplies.
module rsa_modexp_ctrl #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FAIL,
        S_PRE_ISSUE,
        S_PRE_WAIT,
        S_SCAN,
        S_SQR_ISSUE,
        S_SQR_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_POST_ISSUE,
        S_POST_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]     x_reg, m_reg, r_reg, r2_reg, xt_reg, a_reg, result_q;
    logic [EXP_WIDTH-1:0] e_reg;
    logic [IW-1:0]        i_reg;
    logic                 err_q;

    logic bit_set, last_bit;
    assign bit_set  = e_reg[i_reg];
    assign last_bit = (i_reg == '0);

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (start) state_nxt = in_m[0] ? S_PRE_ISSUE : S_FAIL;
            S_FAIL:       state_nxt = S_IDLE;
            S_PRE_ISSUE:  state_nxt = S_PRE_WAIT;
`ifdef MODEXP_LZ_SKIP_EN
            S_PRE_WAIT:   if (mm_done) state_nxt = S_SCAN;
            S_SCAN: begin
                if (bit_set)       state_nxt = S_SQR_ISSUE;
                else if (last_bit) state_nxt = S_POST_ISSUE;  // E == 0: A is still R
            end
`else
            S_PRE_WAIT:   if (mm_done) state_nxt = S_SQR_ISSUE;
`endif
            S_SQR_ISSUE:  state_nxt = S_SQR_WAIT;
            S_SQR_WAIT: begin
                if (mm_done) begin
                    if (bit_set)       state_nxt = S_MUL_ISSUE;
                    else if (last_bit) state_nxt = S_POST_ISSUE;
                    else               state_nxt = S_SQR_ISSUE;
                end
            end
            S_MUL_ISSUE:  state_nxt = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mm_done) state_nxt = last_bit ? S_POST_ISSUE : S_SQR_ISSUE;
            end
            S_POST_ISSUE: state_nxt = S_POST_WAIT;
            S_POST_WAIT:  if (mm_done) state_nxt = S_DONE;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, accumulator, bit index, result/err.
    // mm_result is only taken in WAIT states, so stray mm_done pulses elsewhere are harmless.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_reg    <= '0;
            e_reg    <= '0;
            m_reg    <= '0;
            r_reg    <= '0;
            r2_reg   <= '0;
            xt_reg   <= '0;
            a_reg    <= '0;
            i_reg    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_reg  <= in_x;
                        e_reg  <= in_e;
                        m_reg  <= in_m;
                        r_reg  <= in_r;
                        r2_reg <= in_r2;
                        // err/result must already be valid in the single FAIL cycle
                        err_q  <= ~in_m[0];
                        if (!in_m[0]) result_q <= '0;
                    end
                end
                S_PRE_WAIT: begin
                    if (mm_done) begin
                        xt_reg <= mm_result;
                        a_reg  <= r_reg;
                        i_reg  <= IW'(EXP_WIDTH - 1);
                    end
                end
`ifdef MODEXP_LZ_SKIP_EN
                S_SCAN: begin
                    if (!bit_set && !last_bit) i_reg <= i_reg - IW'(1);
                end
`endif
                S_SQR_WAIT: begin
                    if (mm_done) begin
                        a_reg <= mm_result;
                        // index stays put when a multiply follows; MUL_WAIT steps it
                        if (!bit_set && !last_bit) i_reg <= i_reg - IW'(1);
                    end
                end
                S_MUL_WAIT: begin
                    if (mm_done) begin
                        a_reg <= mm_result;
                        if (!last_bit) i_reg <= i_reg - IW'(1);
                    end
                end
                S_POST_WAIT: begin
                    if (mm_done) result_q <= mm_result;
                end
                default: ;
            endcase
        end
    end

    // Outputs: operands are a pure function of state and registers that only
    // change on capture, so they are stable for the whole WAIT.
    always_comb begin
        mm_start = 1'b0;
        mm_a     = '0;
        mm_b     = '0;
        done     = 1'b0;
        busy     = 1'b1;
        case (state)
            S_IDLE:       busy = 1'b0;
            S_FAIL: begin
                done = 1'b1;
                busy = 1'b0;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b0;
            end
            S_PRE_ISSUE, S_PRE_WAIT: begin
                mm_start = (state == S_PRE_ISSUE);
                mm_a     = x_reg;
                mm_b     = r2_reg;
            end
            S_SQR_ISSUE, S_SQR_WAIT: begin
                mm_start = (state == S_SQR_ISSUE);
                mm_a     = a_reg;
                mm_b     = a_reg;
            end
            S_MUL_ISSUE, S_MUL_WAIT: begin
                mm_start = (state == S_MUL_ISSUE);
                mm_a     = a_reg;
                mm_b     = xt_reg;
            end
            S_POST_ISSUE, S_POST_WAIT: begin
                mm_start = (state == S_POST_ISSUE);
                mm_a     = a_reg;
                mm_b     = WIDTH'(1);
            end
            default: ;
        endcase
    end

    assign mm_m   = m_reg;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Purpose : self-checking bench for rsa_modexp_ctrl with an 8-bit behavioural Montgomery multiplier.
// Latency : model answers each mm_start five cycles later with a one-cycle mm_done.
// Backpressure: none; stimulus waits for done with a bounded cycle budget.
module tb_rsa_modexp_ctrl;

    localparam int W  = 8;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          resetn, start;
    logic [W-1:0]  in_x, in_m, in_r, in_r2;
    logic [EW-1:0] in_e;
    logic          mm_start, mm_done, done, busy, err;
    logic [W-1:0]  mm_a, mm_b, mm_m, mm_result, result;
    logic          model_done, inj_done;

    assign mm_done = model_done | inj_done;

    int checks = 0;
    int errors = 0;
    int starts_tot = 0;
    int dones_tot  = 0;
    int stab_bad   = 0;

    always #5 clk = ~clk;

    rsa_modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done),
        .result(result), .done(done), .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // a*b*2^-8 mod m
    function automatic int mont(input int a, input int b, input int m);
        int rinv;
        rinv = 0;
        for (int r = 1; r < m; r++)
            if ((256 * r) % m == 1) rinv = r;
        return (((a * b) % m) * rinv) % m;
    endfunction

    function automatic int powmod(input int x, input int e, input int m);
        int r;
        r = 1 % m;
        for (int k = 0; k < e; k++) r = (r * x) % m;
        return r;
    endfunction

    function automatic int exp_mults(input int e);
        int pc, msb;
        pc = 0;
        msb = -1;
        for (int k = 0; k < EW; k++)
            if (((e >> k) & 1) == 1) begin
                pc++;
                msb = k;
            end
`ifdef MODEXP_LZ_SKIP_EN
        return (e == 0) ? 2 : 2 + msb + 1 + pc;
`else
        return 2 + EW + pc + 0 * msb;
`endif
    endfunction

    // Behavioural multiplier
    initial begin
        int a, b, m, v;
        model_done = 1'b0;
        mm_result  = '0;
        forever begin
            @(negedge clk);
            if (mm_start === 1'b1) begin
                a = int'(mm_a);
                b = int'(mm_b);
                m = int'(mm_m);
                v = (m > 1) ? mont(a, b, m) : 0;
                repeat (5) @(negedge clk);
                #1;
                mm_result  = 8'(v);
                model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
            end
        end
    end

    // Monitor: event counters and operand stability during each WAIT
    initial begin
        bit           waiting, pd;
        logic [W-1:0] ca, cb, cm;
        waiting = 0;
        ca = '0; cb = '0; cm = '0;
        forever begin
            @(posedge clk);
            pd = (mm_done === 1'b1);
            @(negedge clk);
            if (resetn !== 1'b1) begin
                waiting = 0;
            end else begin
                if (waiting && !pd)
                    if (mm_a !== ca || mm_b !== cb || mm_m !== cm) stab_bad++;
                if (pd) waiting = 0;
                if (mm_start === 1'b1) begin
                    waiting = 1;
                    ca = mm_a; cb = mm_b; cm = mm_m;
                    starts_tot++;
                end
                if (done === 1'b1) dones_tot++;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mm_start"}, mm_start, 0);
        chk({tag, "_mm_a"}, mm_a, 0);
        chk({tag, "_mm_b"}, mm_b, 0);
        chk({tag, "_mm_m"}, mm_m, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_run(input string tag, input int x, input int e, input int m,
                          input bit dbl, input bit inj);
        int  s0, d0, loc, r;
        bit  got, odd;
        odd = (m % 2) == 1;
        r   = 256 % m;
        @(negedge clk);
        in_x  = 8'(x);
        in_e  = 8'(e);
        in_m  = 8'(m);
        in_r  = 8'(r);
        in_r2 = 8'((r * r) % m);
        start = 1'b1;
        s0 = starts_tot;
        d0 = dones_tot;
        @(negedge clk);
        start = 1'b0;
        if (odd) begin
            chk({tag, "_busy_on"}, busy, 1);
        end else begin
            chk({tag, "_fail_done"}, done, 1);
            chk({tag, "_fail_err"}, err, 1);
            chk({tag, "_fail_result"}, result, 0);
        end
        got = 0;
        loc = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            if (dbl && k == 3) begin
                start = 1'b1;
                in_e  = ~in_e;
                in_x  = 8'((x + 1) % m);
            end
            if (dbl && k == 4) start = 1'b0;
            if (inj && mm_start === 1'b1) begin
                loc++;
                if (loc == 2) begin
                    #1 inj_done = 1'b1;
                    @(posedge clk);
                    #1 inj_done = 1'b0;
                end
            end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_result"}, result, odd ? powmod(x, e, m) : 0);
        chk({tag, "_err"}, err, odd ? 0 : 1);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_mm_starts"}, starts_tot - s0, odd ? exp_mults(e) : 0);
        repeat (3) @(negedge clk);
        chk({tag, "_done_count"}, dones_tot - d0, 1);
    endtask

    initial begin
        int loc, bad, m, x, e;
        bit hit;
        resetn = 1'b0; start = 1'b0; inj_done = 1'b0;
        in_x = '0; in_e = '0; in_m = '0; in_r = '0; in_r2 = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        resetn = 1'b1;

        // stray mm_done while idle
        @(negedge clk);
        #1 inj_done = 1'b1;
        @(posedge clk);
        #1 inj_done = 1'b0;
        @(negedge clk);
        chk("idle_spur_busy", busy, 0);
        chk("idle_spur_done", done, 0);
        chk("idle_spur_mm_start", mm_start, 0);

        do_run("m13_x5_e3", 5, 3, 13, 0, 0);
        do_run("m13_x7_e0", 7, 0, 13, 0, 0);
        do_run("m12_even", 5, 3, 12, 0, 0);
        do_run("double_start", 5, 3, 13, 1, 0);
        do_run("issue_spur", 5, 3, 13, 0, 1);

        // reset in the 4th WAIT
        @(negedge clk);
        in_x = 8'd5; in_e = 8'd3; in_m = 8'd13; in_r = 8'd9; in_r2 = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        loc = 0;
        hit = 0;
        for (int k = 0; k < 200; k++) begin
            if (mm_start === 1'b1) loc++;
            if (loc == 4) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reach_4th", hit, 1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        resetn = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || mm_start !== 1'b0) bad++;
        end
        chk("late_done_quiet", bad, 0);
        chk("late_done_result", result, 0);
        do_run("after_rst", 2, 5, 13, 0, 0);

        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 5) == 0) m = 2 * int'($urandom_range(1, 127));
            else                           m = 2 * int'($urandom_range(1, 127)) + 1;
            x = int'($urandom_range(0, m - 1));
            e = int'($urandom_range(0, 255));
            do_run($sformatf("rand%0d", n), x, e, m, 0, 0);
        end

        chk("wait_operands_stable", stab_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
